// File: rtl/led_pio_blink.sv
// Avalon-MM LED output port with atomic set/clear, per-bit blink and global PWM dimming.
// Zero-wait-state slave; out_port is a single registered stage driving the pins.
module led_pio_blink #(
  parameter int              WIDTH     = 8,
  parameter int              PERIOD_W  = 24,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  typedef enum logic [2:0] {
    A_DATA   = 3'd0,
    A_BLINK  = 3'd1,
    A_PERIOD = 3'd2,
    A_SET    = 3'd3,
    A_CLEAR  = 3'd4,
    A_DUTY   = 3'd5
  } reg_addr_e;

  localparam logic [PERIOD_W-1:0] PERIOD_ONE = PERIOD_W'(1);

  logic                wr;
  logic                period_wr;
  logic [WIDTH-1:0]    wr_bits;
  logic                pwm_on;
  logic                unused_wd;

  logic [WIDTH-1:0]    data_q,     data_d;
  logic [WIDTH-1:0]    blink_en_q, blink_en_d;
  logic [PERIOD_W-1:0] period_q,   period_d;
  logic [7:0]          duty_q,     duty_d;
  logic [PERIOD_W-1:0] blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [7:0]          pwm_cnt_q,  pwm_cnt_d;
  logic [WIDTH-1:0]    out_q,      out_d;

  assign wr        = chipselect & ~write_n;
  assign period_wr = wr && (address == A_PERIOD);
  assign wr_bits   = writedata[WIDTH-1:0];
  // Register bits beyond the implemented widths are intentionally dropped.
  assign unused_wd = ^writedata;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    data_d     = data_q;
    blink_en_d = blink_en_q;
    period_d   = period_q;
    duty_d     = duty_q;
    if (wr) begin
      case (address)
        A_DATA:   data_d     = wr_bits;
        A_BLINK:  blink_en_d = wr_bits;
        A_PERIOD: period_d   = writedata[PERIOD_W-1:0];
        A_SET:    data_d     = data_q | wr_bits;
        A_CLEAR:  data_d     = data_q & ~wr_bits;
        A_DUTY:   duty_d     = writedata[7:0];
        default:  ;
      endcase
    end
  end

  // A PERIOD write restarts the half-period with phase on, so shrinking
  // PERIOD below the running count can never leave the counter stranded.
  always_comb begin
    blink_cnt_d   = blink_cnt_q + PERIOD_ONE;
    blink_phase_d = blink_phase_q;
    if (period_wr || (period_q == '0)) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (blink_cnt_q == period_q - PERIOD_ONE) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  assign pwm_cnt_d = pwm_cnt_q + 8'd1;
  assign pwm_on    = (duty_q == 8'hFF) | (pwm_cnt_q < duty_q);
  assign out_d     = data_q & (~blink_en_q | {WIDTH{blink_phase_q}}) & {WIDTH{pwm_on}};

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q        <= RESET_VAL;
      blink_en_q    <= '0;
      period_q      <= '0;
      duty_q        <= 8'hFF;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      pwm_cnt_q     <= '0;
      out_q         <= '0;
    end else begin
      data_q        <= data_d;
      blink_en_q    <= blink_en_d;
      period_q      <= period_d;
      duty_q        <= duty_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pwm_cnt_q     <= pwm_cnt_d;
      out_q         <= out_d;
    end
  end

  assign out_port = out_q;

  always_comb begin
    readdata = '0;
    case (address)
      A_DATA:   readdata[WIDTH-1:0]    = data_q;
      A_BLINK:  readdata[WIDTH-1:0]    = blink_en_q;
      A_PERIOD: readdata[PERIOD_W-1:0] = period_q;
      A_DUTY:   readdata[7:0]          = duty_q;
      default:  readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pio_blink.sv
// Directed bench for led_pio_blink: register vector table plus blink, PWM and reset sequences.
module tb_led_pio_blink;

  localparam logic [7:0] RV = 8'h5A;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_vec = 0;
  int n_err = 0;

  led_pio_blink #(.WIDTH(8), .PERIOD_W(24), .RESET_VAL(RV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] exp_rd;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  // Called at a falling edge: the write is sampled on the next rising edge,
  // and the task returns on the falling edge after it.
  task automatic bus_write(input logic cs, input logic [2:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic reset_readback(input string tag);
    read_check({tag, "_data"},   3'd0, {24'h0, RV});
    read_check({tag, "_blink"},  3'd1, 32'h0);
    read_check({tag, "_period"}, 3'd2, 32'h0);
    read_check({tag, "_set"},    3'd3, 32'h0);
    read_check({tag, "_clear"},  3'd4, 32'h0);
    read_check({tag, "_duty"},   3'd5, 32'h0000_00FF);
    read_check({tag, "_rsv6"},   3'd6, 32'h0);
    read_check({tag, "_rsv7"},   3'd7, 32'h0);
  endtask

  initial begin
    int on_cnt, off_cnt, bad_cnt;
    logic [7:0] exp_o;

    vecs[0]  = '{1'b1, 3'd0, 32'h0000_00A5, 3'd0, 32'h0000_00A5, 8'hA5};
    vecs[1]  = '{1'b1, 3'd3, 32'h0000_000F, 3'd0, 32'h0000_00AF, 8'hAF};
    vecs[2]  = '{1'b1, 3'd4, 32'h0000_0081, 3'd0, 32'h0000_002E, 8'h2E};
    vecs[3]  = '{1'b1, 3'd3, 32'h0000_00FF, 3'd3, 32'h0000_0000, 8'hFF};
    vecs[4]  = '{1'b1, 3'd4, 32'h0000_00F0, 3'd4, 32'h0000_0000, 8'h0F};
    vecs[5]  = '{1'b1, 3'd6, 32'hFFFF_FFFF, 3'd6, 32'h0000_0000, 8'h0F};
    vecs[6]  = '{1'b1, 3'd7, 32'hFFFF_FFFF, 3'd7, 32'h0000_0000, 8'h0F};
    vecs[7]  = '{1'b0, 3'd0, 32'h0000_0055, 3'd0, 32'h0000_000F, 8'h0F};
    vecs[8]  = '{1'b0, 3'd3, 32'h0000_00F0, 3'd0, 32'h0000_000F, 8'h0F};
    vecs[9]  = '{1'b1, 3'd1, 32'h0000_00F0, 3'd1, 32'h0000_00F0, 8'h0F};
    vecs[10] = '{1'b1, 3'd2, 32'h1234_5678, 3'd2, 32'h0034_5678, 8'h0F};
    vecs[11] = '{1'b1, 3'd2, 32'h0000_0000, 3'd2, 32'h0000_0000, 8'h0F};
    vecs[12] = '{1'b1, 3'd1, 32'h0000_0000, 3'd1, 32'h0000_0000, 8'h0F};
    vecs[13] = '{1'b1, 3'd5, 32'h0000_01FF, 3'd5, 32'h0000_00FF, 8'h0F};
    vecs[14] = '{1'b1, 3'd0, 32'hFFFF_FF00, 3'd0, 32'h0000_0000, 8'h00};

    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    repeat (3) @(negedge clk);
    check("rst_out", {24'h0, out_port}, 32'h0);
    reset_readback("rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_first_out", {24'h0, out_port}, {24'h0, RV});

    for (int i = 0; i < 15; i++) begin
      bus_write(vecs[i].cs, vecs[i].waddr, vecs[i].wdata);
      read_check($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rd);
      @(negedge clk);
      check($sformatf("vec%0d_out", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
    end

    // Blink: upper nibble alternates every 4 clocks, lower nibble steady.
    bus_write(1'b1, 3'd0, 32'hFF);
    bus_write(1'b1, 3'd1, 32'hF0);
    bus_write(1'b1, 3'd2, 32'd4);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      exp_o = ((((k - 1) / 4) % 2) == 0) ? 8'hFF : 8'h0F;
      check($sformatf("blink_k%0d", k), {24'h0, out_port}, {24'h0, exp_o});
    end
    // Restart mid-cycle: phase on again and a fresh 4-clock half-period.
    bus_write(1'b1, 3'd2, 32'd4);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_o = ((((k - 1) / 4) % 2) == 0) ? 8'hFF : 8'h0F;
      check($sformatf("restart_k%0d", k), {24'h0, out_port}, {24'h0, exp_o});
    end

    // PWM dimming over a full 256-clock window for three duty settings.
    bus_write(1'b1, 3'd1, 32'h0);
    bus_write(1'b1, 3'd5, 32'h40);
    @(negedge clk);
    on_cnt = 0; off_cnt = 0; bad_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      if (out_port === 8'hFF) on_cnt++;
      else if (out_port === 8'h00) off_cnt++;
      else bad_cnt++;
      @(negedge clk);
    end
    check("pwm40_on", 32'(on_cnt), 32'd64);
    check("pwm40_off", 32'(off_cnt), 32'd192);
    check("pwm40_other", 32'(bad_cnt), 32'd0);

    bus_write(1'b1, 3'd5, 32'h00);
    @(negedge clk);
    bad_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      if (out_port !== 8'h00) bad_cnt++;
      @(negedge clk);
    end
    check("pwm00_nonzero", 32'(bad_cnt), 32'd0);

    bus_write(1'b1, 3'd5, 32'hFF);
    @(negedge clk);
    bad_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      if (out_port !== 8'hFF) bad_cnt++;
      @(negedge clk);
    end
    check("pwmFF_not_full", 32'(bad_cnt), 32'd0);

    // PERIOD=0 holds blinking bits on.
    bus_write(1'b1, 3'd0, 32'h3C);
    bus_write(1'b1, 3'd1, 32'hFF);
    bus_write(1'b1, 3'd2, 32'd0);
    bad_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_port !== 8'h3C) bad_cnt++;
    end
    check("period0_steady", 32'(bad_cnt), 32'd0);

    // Reset in the middle of blinking and dimming.
    bus_write(1'b1, 3'd2, 32'd3);
    bus_write(1'b1, 3'd5, 32'h80);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("midrst_out_async", {24'h0, out_port}, 32'h0);
    reset_readback("midrst");
    @(negedge clk);
    check("midrst_out_held", {24'h0, out_port}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst_first_out", {24'h0, out_port}, {24'h0, RV});
    bad_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_port !== RV) bad_cnt++;
    end
    check("midrst_steady", 32'(bad_cnt), 32'd0);
    reset_readback("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
